// File: rtl/cache_fill_if.sv
// cache_fill_if: miss request, victim, cache array and main-memory signals of the fill engine
interface cache_fill_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int WORDS_PER_BLOCK = 8
);
    localparam int OFF = $clog2(WORDS_PER_BLOCK);
    logic              miss_detected;
    logic [ADDR_W-1:0] miss_address;
    logic              victim_dirty;
    logic [ADDR_W-1:0] victim_address;
    logic [DATA_W-1:0] cache_rdata;
    logic              mem_data_valid;
    logic [DATA_W-1:0] mem_rdata;
    logic              fsm_busy;
    logic              mem_en;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [OFF-1:0]    cache_word_sel;
    logic              write_data_array;
    logic [OFF-1:0]    fill_word;
    logic [DATA_W-1:0] fill_data;
    logic              write_tag_array;
    logic              done;
    modport master (
        input  miss_detected, miss_address, victim_dirty, victim_address,
               cache_rdata, mem_data_valid, mem_rdata,
        output fsm_busy, mem_en, mem_wr, mem_addr, mem_wdata, cache_word_sel,
               write_data_array, fill_word, fill_data, write_tag_array, done
    );
    modport slave (
        output miss_detected, miss_address, victim_dirty, victim_address,
               cache_rdata, mem_data_valid, mem_rdata,
        input  fsm_busy, mem_en, mem_wr, mem_addr, mem_wdata, cache_word_sel,
               write_data_array, fill_word, fill_data, write_tag_array, done
    );
endinterface

// File: rtl/cache_fill_engine.sv
// cache_fill_engine: one-miss-at-a-time block fill with dirty victim write-back and optional critical-word-first
module cache_fill_engine #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int WORDS_PER_BLOCK = 8,
    parameter int CWF = 0
) (
    input logic clk,
    input logic rst_n,
    cache_fill_if.master bus
);
    localparam int OFF = $clog2(WORDS_PER_BLOCK);
    localparam int HI = ADDR_W - OFF - 1;
    localparam logic [OFF:0] W_N = (OFF+1)'(WORDS_PER_BLOCK);
    localparam logic [OFF:0] R_LAST = (OFF+1)'(WORDS_PER_BLOCK - 1);
    localparam logic [OFF-1:0] WB_LAST = OFF'(WORDS_PER_BLOCK - 1);
    typedef enum logic [1:0] {IDLE, WB, FILL, TAG} state_t;
    state_t            state_q;
    logic [HI-1:0]     base_q, vbase_q;
    logic [OFF-1:0]    start_q, wb_q;
    logic [OFF:0]      iss_q, ret_q;
    logic              busy_q, en_q, wr_q, tag_q, done_q;
    logic [ADDR_W-1:0] addr_q;
    logic              wr_fill;
    logic [OFF-1:0]    miss_start, iss_word;
    logic              unused_ok;
    function automatic logic [ADDR_W-1:0] word_addr(input logic [HI-1:0] hi, input logic [OFF-1:0] idx);
        return {hi, idx, 1'b0};
    endfunction
    assign miss_start = CWF != 0 ? bus.miss_address[OFF:1] : '0;
    assign iss_word = start_q + iss_q[OFF-1:0];
    assign wr_fill = state_q == FILL && bus.mem_data_valid && ret_q < W_N;
    assign unused_ok = ^{bus.miss_address[OFF:0], bus.victim_address[OFF:0]};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            base_q  <= '0;
            vbase_q <= '0;
            start_q <= '0;
            wb_q    <= '0;
            iss_q   <= '0;
            ret_q   <= '0;
            busy_q  <= 1'b0;
            en_q    <= 1'b0;
            wr_q    <= 1'b0;
            tag_q   <= 1'b0;
            done_q  <= 1'b0;
            addr_q  <= '0;
        end else begin
            done_q <= 1'b0;
            tag_q  <= 1'b0;
            case (state_q)
                IDLE: if (bus.miss_detected) begin
                    base_q  <= bus.miss_address[ADDR_W-1:OFF+1];
                    vbase_q <= bus.victim_address[ADDR_W-1:OFF+1];
                    start_q <= miss_start;
                    wb_q    <= '0;
                    ret_q   <= '0;
                    busy_q  <= 1'b1;
                    en_q    <= 1'b1;
                    wr_q    <= bus.victim_dirty;
                    state_q <= bus.victim_dirty ? WB : FILL;
                    iss_q   <= bus.victim_dirty ? '0 : (OFF+1)'(1);
                    addr_q  <= bus.victim_dirty ? word_addr(bus.victim_address[ADDR_W-1:OFF+1], '0)
                                                : word_addr(bus.miss_address[ADDR_W-1:OFF+1], miss_start);
                end
                WB: if (wb_q == WB_LAST) begin
                    state_q <= FILL;
                    wr_q    <= 1'b0;
                    addr_q  <= word_addr(base_q, start_q);
                    iss_q   <= (OFF+1)'(1);
                end else begin
                    wb_q   <= wb_q + 1'b1;
                    addr_q <= word_addr(vbase_q, wb_q + 1'b1);
                end
                FILL: begin
                    en_q <= iss_q < W_N;
                    if (iss_q < W_N) begin
                        addr_q <= word_addr(base_q, iss_word);
                        iss_q  <= iss_q + 1'b1;
                    end
                    if (wr_fill) begin
                        ret_q <= ret_q + 1'b1;
                        if (ret_q == R_LAST) begin
                            state_q <= TAG;
                            tag_q   <= 1'b1;
                            en_q    <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
            endcase
        end
    end
    assign bus.fsm_busy         = busy_q;
    assign bus.mem_en           = en_q;
    assign bus.mem_wr           = wr_q;
    assign bus.mem_addr         = addr_q;
    assign bus.mem_wdata        = DATA_W'(bus.cache_rdata);
    assign bus.cache_word_sel   = wb_q;
    assign bus.write_data_array = wr_fill;
    assign bus.fill_word        = start_q + ret_q[OFF-1:0];
    assign bus.fill_data        = DATA_W'(bus.mem_rdata);
    assign bus.write_tag_array  = tag_q;
    assign bus.done             = done_q;
endmodule

// File: tb/tb_cache_fill_engine.sv
// tb_cache_fill_engine: directed checks of three engine configurations against a 4-cycle pipelined memory
module tb_cache_fill_engine;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;
    logic [2:0] miss, dirty, spur;
    logic [15:0] maddr[3], vaddr[3];
    wire [2:0] busy, en, wr, wda, tag, dn;
    wire [15:0] addr[3], wdata[3], fdata[3];
    wire [2:0] sel[3], fw[3];
    int errors = 0;
    int checks = 0;
    for (genvar g = 0; g < 3; g++) begin : u
        localparam int W = g == 2 ? 4 : 8;
        localparam int C = g == 0 ? 0 : 1;
        logic [3:0] pv;
        logic [15:0] pa[4];
        cache_fill_if #(.WORDS_PER_BLOCK(W)) bus ();
        cache_fill_engine #(.WORDS_PER_BLOCK(W), .CWF(C)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.master));
        always @(posedge clk or negedge rst_n)
            if (!rst_n) pv <= '0;
            else pv <= {pv[2:0], bus.mem_en & ~bus.mem_wr};
        always @(posedge clk) begin
            pa[0] <= bus.mem_addr;
            pa[1] <= pa[0];
            pa[2] <= pa[1];
            pa[3] <= pa[2];
        end
        assign bus.miss_detected  = miss[g];
        assign bus.victim_dirty   = dirty[g];
        assign bus.miss_address   = maddr[g];
        assign bus.victim_address = vaddr[g];
        assign bus.cache_rdata    = 16'hC000 | 16'(bus.cache_word_sel);
        assign bus.mem_data_valid = pv[3] | spur[g];
        assign bus.mem_rdata      = pa[3] ^ 16'h5A5A;
        assign busy[g]  = bus.fsm_busy;
        assign en[g]    = bus.mem_en;
        assign wr[g]    = bus.mem_wr;
        assign wda[g]   = bus.write_data_array;
        assign tag[g]   = bus.write_tag_array;
        assign dn[g]    = bus.done;
        assign addr[g]  = bus.mem_addr;
        assign wdata[g] = bus.mem_wdata;
        assign fdata[g] = bus.fill_data;
        assign sel[g]   = 3'(bus.cache_word_sel);
        assign fw[g]    = 3'(bus.fill_word);
    end
    task automatic chk(input string t, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", t, got, exp);
        end
    endtask
    task automatic run_txn(input int d, input int w, input logic dty, input logic [15:0] ma, input logic [15:0] va,
                           input int start, input bit hold, input bit spr, input int kmax);
        int wb = dty ? w : 0;
        int t = wb + w + 4 + 2;
        int lim = kmax != 0 ? kmax : t;
        int j, r;
        logic e_en;
        logic [15:0] mb = ma & ~16'(2 * w - 1);
        logic [15:0] vb = va & ~16'(2 * w - 1);
        miss[d] = 1'b1;
        dirty[d] = dty;
        maddr[d] = ma;
        vaddr[d] = va;
        for (int k = 1; k <= lim; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (!hold) miss[d] = 1'b0;
            j = k - wb - 1;
            r = j - 4;
            e_en = k <= wb || (j >= 0 && j < w);
            chk("busy", busy[d], 32'(k < t));
            chk("mem_en", en[d], 32'(e_en));
            if (k <= wb) begin
                chk("wb_wr", wr[d], 1);
                chk("wb_addr", addr[d], vb + 2 * (k - 1));
                chk("wb_sel", sel[d], k - 1);
                chk("wb_wdata", wdata[d], 16'hC000 + k - 1);
            end else if (e_en) begin
                chk("rd_wr", wr[d], 0);
                chk("rd_addr", addr[d], mb + 2 * ((start + j) % w));
            end
            chk("write_data", wda[d], 32'(r >= 0 && r < w));
            if (r >= 0 && r < w) begin
                chk("fill_word", fw[d], (start + r) % w);
                chk("fill_data", fdata[d], (mb + 2 * ((start + r) % w)) ^ 16'h5A5A);
            end
            chk("tag", tag[d], 32'(k == t - 1));
            chk("done", dn[d], 32'(k == t));
            spur[d] = spr && k + 1 > wb + w + 4 && k + 1 <= wb + w + 7;
        end
    endtask
    initial begin
        rst_n = 1'b0;
        miss = '0;
        dirty = '0;
        spur = '0;
        for (int d = 0; d < 3; d++) begin
            maddr[d] = '0;
            vaddr[d] = '0;
        end
        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk("rst_busy", busy[d], 0);
            chk("rst_en", en[d], 0);
            chk("rst_tag", tag[d], 0);
            chk("rst_done", dn[d], 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        run_txn(0, 8, 1'b0, 16'h1234, 16'h0000, 0, 1'b0, 1'b0, 0);
        run_txn(1, 8, 1'b0, 16'h1234, 16'h0000, 2, 1'b0, 1'b0, 0);
        run_txn(0, 8, 1'b1, 16'h1234, 16'h0A50, 0, 1'b0, 1'b0, 0);
        run_txn(0, 8, 1'b0, 16'h1234, 16'h0000, 0, 1'b1, 1'b1, 0);
        run_txn(0, 8, 1'b1, 16'h1234, 16'h0A57, 0, 1'b0, 1'b0, 0);
        repeat (3) begin
            @(negedge clk);
            chk("idle_busy", busy[0], 0);
            chk("idle_wda", wda[0], 0);
        end
        run_txn(0, 8, 1'b0, 16'h1234, 16'h0000, 0, 1'b0, 1'b0, 6);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy[0], 0);
        chk("mid_rst_en", en[0], 0);
        chk("mid_rst_wr", wr[0], 0);
        chk("mid_rst_addr", addr[0], 0);
        chk("mid_rst_wda", wda[0], 0);
        chk("mid_rst_fw", fw[0], 0);
        chk("mid_rst_sel", sel[0], 0);
        chk("mid_rst_tag", tag[0], 0);
        chk("mid_rst_done", dn[0], 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("post_rst_tag", tag[0], 0);
            chk("post_rst_busy", busy[0], 0);
        end
        run_txn(0, 8, 1'b0, 16'h1234, 16'h0000, 0, 1'b0, 1'b0, 0);
        run_txn(2, 4, 1'b0, 16'hFFFE, 16'h0000, 3, 1'b0, 1'b0, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cache_fill_engine.md
Name: cache_fill_engine

Overview:
- Parametrised successor to the D-cache fill FSM: services one cache miss at a time against the pipelined main memory (memory4c-style: one request per cycle, data_valid returned a fixed number of cycles later).
- Adds write-back of a dirty victim block before the fill.
- Adds configurable block size and optional critical-word-first fill ordering.
- Sits between the MEM-stage cache arrays and main memory; its busy output feeds the pipeline cache stall.

Parameters:
ADDR_W, 16, byte address width
DATA_W, 16, word width; words are 2 bytes, so word offset is addr[OFF:1] with OFF = log2(WORDS_PER_BLOCK)
WORDS_PER_BLOCK, 8, words per cache block; power of two, >= 2
CWF, 0, 1 = critical word first (fill starts at the missed word, wraps within block); 0 = fill from word 0

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
miss_detected  in  1  miss request; sampled only in IDLE
miss_address  in  ADDR_W  faulting address; captured with the accepted miss
victim_dirty  in  1  victim block needs write-back; captured with the accepted miss
victim_address  in  ADDR_W  victim block address; low OFF+1 bits ignored; captured with the accepted miss
cache_rdata  in  DATA_W  cache data for the word at cache_word_sel (combinational read)
mem_data_valid  in  1  main-memory read data valid
mem_rdata  in  DATA_W  main-memory read data
fsm_busy  out  1  high whenever state != IDLE
mem_en  out  1  memory request strobe
mem_wr  out  1  1 = write request, 0 = read request
mem_addr  out  ADDR_W  request address
mem_wdata  out  DATA_W  write data; equals cache_rdata
cache_word_sel  out  OFF  word index for victim read during write-back
write_data_array  out  1  write fill_data into cache word fill_word
fill_word  out  OFF  word index of the current fill write
fill_data  out  DATA_W  equals mem_rdata
write_tag_array  out  1  one-cycle pulse: update tag, valid and LRU
done  out  1  one-cycle pulse in the cycle the FSM returns to IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all counters 0; every output 0. Reset mid-operation abandons the transaction; no tag write occurs.
- States: IDLE, WB, FILL, TAG.
- IDLE:
  - miss_detected=1 captures miss_address, victim_address and victim_dirty.
  - Block base = miss_address with bits [OFF:0] cleared.
  - Next state is WB if victim_dirty, else FILL.
- WB: lasts exactly WORDS_PER_BLOCK cycles, one write per cycle.
  - Word i is written with mem_en=1, mem_wr=1, mem_addr = victim base + 2i, cache_word_sel=i, mem_wdata=cache_rdata.
  - After word W-1, go to FILL. mem_data_valid is ignored in WB.
- FILL: two independent counters, issue count and return count.
  - Issue: while issue count < W, drive mem_en=1, mem_wr=0, mem_addr = base + 2*((start+issue) mod W); then issue count increments.
  - start = miss word offset if CWF=1, else 0. The address never leaves the block.
  - Return: each mem_data_valid while return count < W asserts write_data_array with fill_word = (start+return) mod W; then return count increments.
  - An issue and a return in the same cycle are both handled.
  - mem_data_valid after W returns is ignored.
  - When the W-th return is written, go to TAG.
- TAG: one cycle with write_tag_array=1; then IDLE with done=1 in that same transition cycle.
- miss_detected while busy is ignored; it is not queued.
- Latency: with memory latency L, a clean miss accepted at cycle 0 gives issues at cycles 1..W, returns at cycles 1+L..W+L, TAG at W+L+1, and IDLE with done at W+L+2. A dirty miss adds W cycles.
- Outputs are decoded from registered state and counters; none depend combinationally on miss_detected.

Test Plan:
- Clean miss, defaults, CWF=0, L=4, miss_address=0x1234 -> reads 0x1230..0x123E at cycles 1..8; write_data_array at cycles 5..12 with fill_word 0..7; write_tag_array at cycle 13; done at 14; fsm_busy high cycles 1..13.
- Same with CWF=1 -> read order 0x1234, 0x1236, ..., 0x123E, 0x1230, 0x1232; fill_word order 2..7, 0, 1.
- Dirty miss, victim_address=0x0A50 -> cycles 1..8: mem_wr=1, addresses 0x0A50..0x0A5E, cache_word_sel 0..7, mem_wdata equals cache_rdata. Then the fill runs as in scenario 1, shifted by 8 cycles (tag write at cycle 21).
- miss_detected held high through a fill, plus 3 spurious mem_data_valid pulses after the 8th return -> exactly one transaction; no extra data or tag writes; a new transaction starts the cycle after done, if miss_detected is still high.
- rst_n low at cycle 6 of a fill -> all outputs 0 immediately; no write_tag_array; next miss restarts from word start.
- WORDS_PER_BLOCK=4, CWF=1, miss_address=0xFFFE -> reads 0xFFFE, 0xFFF8, 0xFFFA, 0xFFFC; no address wraps outside the block.
